// File: rtl/adc_udp_pkt_ctrl.sv
// rtl/adc_udp_pkt_ctrl.sv - UDP packet launch/framing controller for the ADC send FIFO
// Launches full or timeout-flushed packets and prepends a 2-word header to FIFO payload.
module adc_udp_pkt_ctrl #(
  parameter int          PKT_WORDS   = 256,
  parameter int          TIMEOUT_CYC = 125000,
  parameter logic [15:0] MAGIC       = 16'hA55A
) (
  input  logic        gmii_tx_clk,
  input  logic        sys_rst_n,
  input  logic        enable_i,
  input  logic [9:0]  fifo_rdusedw_i,
  input  logic [31:0] fifo_rd_data_i,
  output logic        fifo_rd_en_o,
  output logic        tx_start_en_o,
  output logic [15:0] tx_byte_num_o,
  input  logic        tx_req_i,
  output logic [31:0] tx_data_o,
  input  logic        tx_done_i,
  output logic        busy_o,
  output logic [15:0] seq_num_o
);

  localparam int             TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [9:0]     PKT_W   = 10'(PKT_WORDS);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, START, SEND, WAIT_DONE} state_t;

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [9:0]    n_q;
  logic [10:0]   k_q;
  logic [15:0]   drop_q;
  logic [15:0]   seq_q;
  logic [15:0]   byte_num_q;
  logic [31:0]   data_q;
  logic          pass_q;
  logic          start_q;

  logic          full_w;
  logic          tout_w;
  logic [9:0]    n_sel_w;
  logic [10:0]   k_last_w;
  logic          payload_w;

  assign full_w    = fifo_rdusedw_i >= PKT_W;
  assign tout_w    = (fifo_rdusedw_i != 10'd0) && (timer_q >= TO_LAST);
  assign n_sel_w   = full_w ? PKT_W : fifo_rdusedw_i;
  assign k_last_w  = {1'b0, n_q} + 11'd2;
  assign payload_w = (state_q == SEND) && (k_q >= 11'd2) && (k_q < k_last_w);

  // A tx_done in the same cycle as a request ends the packet, so that word stays in the FIFO.
  assign fifo_rd_en_o  = payload_w && tx_req_i && !tx_done_i;
  assign tx_start_en_o = start_q;
  assign tx_byte_num_o = byte_num_q;
  assign tx_data_o     = pass_q ? fifo_rd_data_i : data_q;
  assign busy_o        = (state_q != IDLE);
  assign seq_num_o     = seq_q;

  always_ff @(posedge gmii_tx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      n_q        <= '0;
      k_q        <= '0;
      drop_q     <= '0;
      seq_q      <= '0;
      byte_num_q <= '0;
      data_q     <= '0;
      pass_q     <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      pass_q  <= 1'b0;
      // Payload words bypass data_q for one cycle; capture them so the value holds afterwards.
      if (pass_q) data_q <= fifo_rd_data_i;
      case (state_q)
        IDLE: begin
          if (tx_req_i) data_q <= '0;
          if (enable_i && (full_w || tout_w)) begin
            n_q        <= n_sel_w;
            byte_num_q <= {4'd0, n_sel_w, 2'b00} + 16'd8;
            start_q    <= 1'b1;
            timer_q    <= '0;
            state_q    <= START;
          end else if (fifo_rdusedw_i == 10'd0) begin
            timer_q <= '0;
          end else if (timer_q != '1) begin
            timer_q <= timer_q + 1'b1;
          end
        end
        START: begin
          if (tx_req_i) data_q <= '0;
          k_q     <= '0;
          state_q <= SEND;
        end
        SEND: begin
          if (tx_done_i) begin
            if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            seq_q   <= seq_q + 16'd1;
            state_q <= IDLE;
          end else if (tx_req_i) begin
            k_q <= k_q + 11'd1;
            if (k_q == 11'd0)      data_q <= {MAGIC, seq_q};
            else if (k_q == 11'd1) data_q <= {4'd0, n_q, 2'b00, drop_q};
            else                   pass_q <= 1'b1;
            if (k_q + 11'd1 == k_last_w) state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (tx_req_i) data_q <= '0;
          if (tx_done_i) begin
            seq_q   <= seq_q + 16'd1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_udp_pkt_ctrl.sv
// tb/tb_adc_udp_pkt_ctrl.sv - self-checking bench for adc_udp_pkt_ctrl
// Packet-level reference model plus FIFO and UDP-engine environment models.
module tb_adc_udp_pkt_ctrl;
  localparam int PKT = 256;
  localparam int TO  = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [9:0]  lvl = '0;
  logic [31:0] rd_data = '0;
  logic        rd_en;
  logic        start;
  logic [15:0] bytes;
  logic        req = 1'b0;
  logic [31:0] data;
  logic        done = 1'b0;
  logic        busy;
  logic [15:0] seq;

  adc_udp_pkt_ctrl #(.PKT_WORDS(PKT), .TIMEOUT_CYC(TO), .MAGIC(16'hA55A)) dut (
    .gmii_tx_clk(clk), .sys_rst_n(rst_n), .enable_i(en), .fifo_rdusedw_i(lvl),
    .fifo_rd_data_i(rd_data), .fifo_rd_en_o(rd_en), .tx_start_en_o(start),
    .tx_byte_num_o(bytes), .tx_req_i(req), .tx_data_o(data), .tx_done_i(done),
    .busy_o(busy), .seq_num_o(seq)
  );

  always #4 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired or underflow", nm);
  endtask

  // Environment FIFO contents and the model's independent copy of the expected word stream.
  logic [31:0] fq[$];
  logic [31:0] eq[$];

  bit          m_act = 0;
  int          m_n, m_reqs, m_start_cyc, m_idle_run;
  logic [15:0] m_seq = '0, m_drop = '0, m_bytes = '0;
  logic [31:0] m_data = '0;
  int          cyc = 0;

  bit eng_on = 0, eng_excess = 0;
  int eng_total, eng_cnt, eng_post, eng_early;
  int req_idx_cur = -1, req_idx_last = -1;

  int          start_cnt = 0, start_cyc_seen = 0, pkt_rd = 0, nz_cyc = 0;
  logic [15:0] last_bytes = '0;
  logic [31:0] hdr0 = '0, hdr1 = '0;
  bit          start_seen = 0, rd_seen = 0;

  bit en_knob = 1, rand_early = 0, rst_req = 0;
  int push_now = 0, prod_rate = 0, early_knob = -1;

  task automatic compare_cycle();
    logic exp_rd;
    exp_rd = m_act && (cyc > m_start_cyc) && (m_reqs >= 2) && (m_reqs < m_n + 2) && req && !done;
    chk("tx_start_en", {31'd0, start}, {31'd0, m_act && (cyc == m_start_cyc)});
    chk("busy", {31'd0, busy}, {31'd0, m_act});
    chk("tx_byte_num", {16'd0, bytes}, {16'd0, m_bytes});
    chk("seq_num", {16'd0, seq}, {16'd0, m_seq});
    chk("fifo_rd_en", {31'd0, rd_en}, {31'd0, exp_rd});
    chk("tx_data", data, m_data);
    if (start) begin
      start_cnt++;
      start_cyc_seen = cyc;
      last_bytes = bytes;
      pkt_rd = 0;
      start_seen = 1;
    end
    if (rd_en) pkt_rd++;
    rd_seen = rd_en;
    if (req_idx_last == 0) hdr0 = data;
    if (req_idx_last == 1) hdr1 = data;
  endtask

  task automatic model_edge();
    if (!m_act) begin
      if (req) m_data = '0;
      if (en && lvl != 0 && (lvl >= PKT || m_idle_run >= TO - 1)) begin
        m_n = (lvl >= PKT) ? PKT : int'(lvl);
        m_act = 1;
        m_start_cyc = cyc + 1;
        m_bytes = 16'((m_n + 2) * 4);
        m_reqs = 0;
        m_idle_run = 0;
      end else begin
        m_idle_run = (lvl != 0) ? m_idle_run + 1 : 0;
      end
    end else if (cyc == m_start_cyc) begin
      if (req) m_data = '0;
    end else if (m_reqs < m_n + 2) begin
      if (done) begin
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        m_seq = m_seq + 16'd1;
        m_act = 0;
      end else if (req) begin
        if (m_reqs == 0) m_data = {16'hA55A, m_seq};
        else if (m_reqs == 1) m_data = {16'(m_n * 4), m_drop};
        else if (eq.size() == 0) fail("model stream empty");
        else m_data = eq.pop_front();
        m_reqs++;
      end
    end else begin
      if (req) m_data = '0;
      if (done) begin
        m_seq = m_seq + 16'd1;
        m_act = 0;
      end
    end
  endtask

  task automatic env_edge();
    int np;
    logic [31:0] w;
    if (rd_seen) begin
      if (fq.size() == 0) fail("fifo underflow");
      else rd_data = fq.pop_front();
    end
    np = push_now;
    push_now = 0;
    if (prod_rate > 0 && $urandom_range(0, 99) < prod_rate) np += $urandom_range(1, 3);
    if (np > 0 && fq.size() == 0) nz_cyc = cyc;
    for (int i = 0; i < np; i++) begin
      if (fq.size() < 1023) begin
        w = $urandom;
        fq.push_back(w);
        eq.push_back(w);
      end
    end
    lvl = 10'(fq.size());
    en = en_knob;

    req_idx_last = req_idx_cur;
    req_idx_cur = -1;
    req = 1'b0;
    done = 1'b0;
    if (start_seen) begin
      start_seen = 0;
      eng_on = 1;
      eng_total = int'(last_bytes) / 4;
      if (eng_total > 1030) eng_total = 1030;
      eng_cnt = 0;
      eng_post = 0;
      eng_excess = ($urandom_range(0, 2) == 0);
      eng_early = early_knob;
      if (rand_early && eng_total > 0 && $urandom_range(0, 7) == 0)
        eng_early = $urandom_range(0, eng_total - 1);
    end
    if (eng_on) begin
      if (eng_early >= 0 && eng_cnt == eng_early) begin
        done = 1'b1;
        eng_on = 0;
      end else if (eng_cnt < eng_total) begin
        if ($urandom_range(0, 3) != 0) begin
          req = 1'b1;
          req_idx_cur = eng_cnt;
          eng_cnt++;
        end
      end else begin
        eng_post++;
        if (eng_post == 2 && eng_excess) req = 1'b1;
        if (eng_post >= 4) begin
          done = 1'b1;
          eng_on = 0;
        end
      end
    end
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    req = 1'b1;
    done = 1'b0;
    #1;
    chk("rst tx_start_en", {31'd0, start}, 32'd0);
    chk("rst tx_byte_num", {16'd0, bytes}, 32'd0);
    chk("rst tx_data", data, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst seq_num", {16'd0, seq}, 32'd0);
    chk("rst fifo_rd_en", {31'd0, rd_en}, 32'd0);
    m_act = 0; m_idle_run = 0; m_data = '0; m_bytes = '0; m_seq = '0; m_drop = '0;
    eng_on = 0; start_seen = 0; rd_seen = 0; req_idx_cur = -1; req_idx_last = -1;
    @(posedge clk);
    #1;
    cyc++;
    chk("rst fifo_rd_en held", {31'd0, rd_en}, 32'd0);
    req = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
    rst_req = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset tx_start_en", {31'd0, start}, 32'd0);
    chk("reset tx_byte_num", {16'd0, bytes}, 32'd0);
    chk("reset tx_data", data, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset seq_num", {16'd0, seq}, 32'd0);
    chk("reset fifo_rd_en", {31'd0, rd_en}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en = en_knob;
    forever begin
      @(negedge clk);
      compare_cycle();
      if (rst_req) begin
        do_reset();
      end else begin
        @(posedge clk);
        #1;
        model_edge();
        cyc++;
        env_edge();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_start(input int c0, input string nm);
    int t;
    t = 0;
    while (start_cnt == c0 && t < 3000) begin step(); t++; end
    if (t >= 3000) fail(nm);
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while ((m_act || eng_on || start_seen) && t < 5000) begin step(); t++; end
    if (t >= 5000) fail(nm);
  endtask

  initial begin
    int c0;
    int t;
    repeat (6) step();

    c0 = start_cnt;
    push_now = 300;
    wait_start(c0, "full start");
    c0 = start_cnt;
    wait_idle("full idle");
    chk("full start count", start_cnt - c0, 0);
    chk("full byte_num", {16'd0, last_bytes}, 32'd1032);
    chk("full hdr0", hdr0, 32'hA55A0000);
    chk("full hdr1", hdr1, 32'h04000000);
    chk("full reads", pkt_rd, 256);
    chk("full seq after", {16'd0, seq}, 32'd1);

    wait_start(c0, "flush44 start");
    c0 = start_cnt;
    chk("flush44 byte_num", {16'd0, last_bytes}, 32'd184);
    wait_idle("flush44 idle");

    repeat (5) step();
    push_now = 10;
    wait_start(c0, "timeout start");
    c0 = start_cnt;
    chk("timeout delay", start_cyc_seen - nz_cyc, 100);
    wait_idle("timeout idle");
    chk("timeout byte_num", {16'd0, last_bytes}, 32'd48);
    chk("timeout hdr0", hdr0, 32'hA55A0002);
    chk("timeout hdr1", hdr1, 32'h00280000);
    chk("timeout reads", pkt_rd, 10);

    early_knob = 50;
    push_now = 320;
    wait_start(c0, "early start");
    c0 = start_cnt;
    early_knob = -1;
    wait_idle("early idle");
    chk("early reads", pkt_rd, 48);
    wait_start(c0, "after-early start");
    c0 = start_cnt;
    wait_idle("after-early idle");
    chk("after-early hdr0", hdr0, 32'hA55A0004);
    chk("after-early hdr1", hdr1, 32'h04000001);
    chk("after-early reads", pkt_rd, 256);
    wait_start(c0, "flush16 start");
    c0 = start_cnt;
    wait_idle("flush16 idle");

    en_knob = 0;
    repeat (3) step();
    c0 = start_cnt;
    push_now = 1000;
    repeat (2 * TO) step();
    chk("disabled starts", start_cnt - c0, 0);
    en_knob = 1;
    wait_start(c0, "enable start");
    en_knob = 0;
    wait_idle("enable-drop idle");
    chk("enable-drop reads", pkt_rd, 256);
    chk("enable-drop starts", start_cnt - c0, 1);

    rand_early = 1;
    for (int i = 0; i < 60; i++) begin
      en_knob = ($urandom_range(0, 4) != 0);
      prod_rate = $urandom_range(0, 60);
      repeat (200) step();
    end
    prod_rate = 0;
    rand_early = 0;
    en_knob = 1;

    push_now = 300;
    t = 0;
    while (!(eng_on && eng_cnt >= 5 && eng_cnt < eng_total) && t < 5000) begin step(); t++; end
    if (t >= 5000) fail("reset-in-send wait");
    rst_req = 1;
    t = 0;
    while (rst_req && t < 100) begin step(); t++; end
    if (t >= 100) fail("reset sequence");
    chk("post-reset seq", {16'd0, seq}, 32'd0);
    c0 = start_cnt;
    push_now = 300;
    wait_start(c0, "post-reset start");
    wait_idle("post-reset idle");
    chk("post-reset hdr0", hdr0, 32'hA55A0000);
    chk("post-reset hdr1 drop", {16'd0, hdr1[15:0]}, 32'd0);

    repeat (4) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_udp_pkt_ctrl.md
Name: adc_udp_pkt_ctrl

Overview:
- Transmit-side packet controller between the ADC send FIFO read port (32-bit, gmii_tx_clk domain) and the UDP transmit engine.
- Decides when to launch a UDP packet: full packet, or a timeout flush of a partial packet.
- Prepends a 2-word header (magic, sequence number, payload length, dropped-packet count) to the ADC payload.
- Drives tx_start_en / tx_byte_num / tx_data and steers tx_req into the FIFO read enable.

Parameters:
- PKT_WORDS, 256, payload words per full packet (1..1023); full packet = 1024 payload bytes.
- TIMEOUT_CYC, 125000, IDLE cycles with a non-empty FIFO before a partial packet is flushed (1 ms at 125 MHz).
- MAGIC, 16'hA55A, header word 0 upper half.

Ports:
- gmii_tx_clk  in  1  clock, 125 MHz.
- sys_rst_n  in  1  reset.
- enable  in  1  level; 0 stops launching new packets.
- fifo_rdusedw  in  10  FIFO read-side fill level in 32-bit words.
- fifo_rd_data  in  32  FIFO read data, valid 1 cycle after fifo_rd_en.
- fifo_rd_en  out  1  FIFO read strobe.
- tx_start_en  out  1  one-cycle launch pulse to the UDP engine.
- tx_byte_num  out  16  packet length in bytes, header included.
- tx_req  in  1  UDP engine word request; data is expected 1 cycle later.
- tx_data  out  32  word to the UDP engine.
- tx_done  in  1  one-cycle packet-complete pulse from the UDP engine.
- busy  out  1  high from START through WAIT_DONE.
- seq_num  out  16  sequence number of the next packet.

Behaviour:
- Reset (sys_rst_n, asynchronous, active-low; clock gmii_tx_clk):
  - All outputs 0; seq_num 0.
  - FSM to IDLE; timer, word counter and drop counter cleared.
  - Reset asserted mid-packet aborts immediately; no further fifo_rd_en.
- FSM states: IDLE, START, SEND, WAIT_DONE.
- IDLE:
  - timer increments (saturating) while fifo_rdusedw != 0; clears when fifo_rdusedw == 0 and on exit from IDLE.
  - If enable && fifo_rdusedw >= PKT_WORDS: n = PKT_WORDS, go to START.
  - Else if enable && fifo_rdusedw != 0 && timer >= TIMEOUT_CYC-1: n = fifo_rdusedw, go to START.
  - The full-packet condition has priority over the timeout condition in the same cycle.
  - n is latched at the transition and never exceeds PKT_WORDS.
- START (one cycle):
  - tx_start_en = 1.
  - tx_byte_num = (n+2)*4, registered and held until the next START.
  - Go to SEND.
- SEND:
  - k counts tx_req pulses, starting at 0.
  - k=0: tx_data next cycle = {MAGIC, seq_num}.
  - k=1: tx_data next cycle = {n*4 [15:0], drop_cnt[15:0]}.
  - k=2..n+1: fifo_rd_en = tx_req (combinational); tx_data = fifo_rd_data.
  - When k reaches n+2, go to WAIT_DONE.
- Excess requests: tx_req beyond n+2 → fifo_rd_en stays 0, tx_data = 0.
- WAIT_DONE:
  - On tx_done: seq_num += 1 (wraps 0xFFFF→0) and go to IDLE.
- tx_done early: if tx_done arrives in SEND before k == n+2:
  - drop_cnt += 1 (saturating at 0xFFFF); seq_num still increments.
  - Go to IDLE; remaining FIFO words stay in the FIFO.
- enable falling mid-packet has no effect; the current packet completes. It only blocks the next launch.
- tx_data is registered and holds its value between requests.
- busy = (state != IDLE).
- fifo_rd_en is never asserted outside SEND. This guarantees no FIFO underflow, since n <= fifo_rdusedw at launch and the read-side count never overestimates.

Test Plan:
- PKT_WORDS=256, fifo_rdusedw=300, enable=1, UDP model issues 258 tx_req then tx_done:
  - Exactly one tx_start_en pulse; tx_byte_num=1032.
  - tx_data[0]=0xA55A0000; tx_data[1]=0x04000000.
  - 256 fifo_rd_en pulses; seq_num=1 afterward.
- fifo_rdusedw held at 10, TIMEOUT_CYC=100:
  - tx_start_en occurs 100 cycles after the level first becomes non-zero.
  - tx_byte_num=48; header word 1 = 0x00280000; exactly 10 FIFO reads.
- tx_done injected after 50 tx_req of a full packet:
  - Return to IDLE; 48 FIFO reads total.
  - Next packet header word 1 low half = 0x0001; seq_num incremented.
- enable=0 with fifo_rdusedw=1000 → no tx_start_en for 2×TIMEOUT_CYC. Drop enable mid-packet → that packet completes normally.
- Assert sys_rst_n=0 during SEND:
  - All outputs 0 asynchronously; seq_num=0.
  - After release, the next packet header word 0 = 0xA55A0000.
- seq_num preloaded to 0xFFFF via 65535 packets (or a forced value): next packet carries 0xFFFF, the following one 0x0000.
